// File: rtl/rob_alloc_pkg.sv
// Shared ROB sizing constants and the occupancy classification used by the
// allocator. Consumers size their ROB index ports from DEF_ROB_ADDR_W.
package rob_alloc_pkg;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_ROB_DEPTH  = 32;
  localparam int DEF_ROB_ADDR_W = 5;
  localparam int DEF_CNT_W      = 3;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

endpackage

// File: rtl/rob_alloc_ptr_adv.sv
// Modulo pointer add for a power-of-two ROB: the sum simply wraps at ADDR_W bits.
module rob_ptr_adv
  import rob_alloc_pkg::*;
#(
  parameter int ADDR_W = DEF_ROB_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic [ADDR_W-1:0] ptr,
  input  logic [CNT_W-1:0]  n,
  output logic [ADDR_W-1:0] res
);

  assign res = ptr + ADDR_W'(n);

endmodule

// File: rtl/rob_alloc.sv
// ROB slot allocator: circular head/tail/count bookkeeping, lane index offer,
// commit reclaim, flush, and sticky protocol-violation detection.
module rob_alloc
  import rob_alloc_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ROB_DEPTH  = DEF_ROB_DEPTH,
  parameter int ROB_ADDR_W = DEF_ROB_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CNT_W-1:0]            alloc_take,
  input  logic [CNT_W-1:0]            commit_count,
  input  logic                        flush,
  output logic [ROB_ADDR_W*WIDTH-1:0] rob_entries,
  output logic [WIDTH-1:0]            alloc_avail,
  output logic [ROB_ADDR_W-1:0]       rob_head,
  output logic [ROB_ADDR_W:0]         rob_count,
  output logic                        rob_full,
  output logic                        rob_empty,
  output logic                        proto_err
);

  logic [ROB_ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_ADDR_W-1:0] head_adv, tail_adv;
  logic [ROB_ADDR_W:0]   count_q, count_d, free_slots;
  logic                  err_q, err_d;
  logic                  take_ok, commit_ok;
  logic [CNT_W-1:0]      take_eff, commit_eff;
  occ_e                  occ;

  assign free_slots = (ROB_ADDR_W+1)'(ROB_DEPTH) - count_q;

  rob_ptr_adv #(.ADDR_W(ROB_ADDR_W), .CNT_W(CNT_W)) u_head_adv (
    .ptr(head_q), .n(commit_eff), .res(head_adv)
  );

  rob_ptr_adv #(.ADDR_W(ROB_ADDR_W), .CNT_W(CNT_W)) u_tail_adv (
    .ptr(tail_q), .n(take_eff), .res(tail_adv)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    rob_ptr_adv #(.ADDR_W(ROB_ADDR_W), .CNT_W(CNT_W)) u_lane_adv (
      .ptr(tail_q), .n(CNT_W'(i)), .res(rob_entries[i*ROB_ADDR_W +: ROB_ADDR_W])
    );
  end

  // Legality uses registered count only: a same-cycle commit frees nothing for allocation.
  always_comb begin
    take_ok    = (alloc_take <= CNT_W'(WIDTH)) &&
                 ((ROB_ADDR_W+1)'(alloc_take) <= free_slots);
    commit_ok  = (commit_count <= CNT_W'(WIDTH)) &&
                 ((ROB_ADDR_W+1)'(commit_count) <= count_q);
    take_eff   = take_ok   ? alloc_take   : '0;
    commit_eff = commit_ok ? commit_count : '0;
    err_d      = err_q | ~take_ok | ~commit_ok;
    head_d     = head_adv;
    if (flush) begin
      tail_d  = head_adv;
      count_d = '0;
    end else begin
      tail_d  = tail_adv;
      count_d = count_q + (ROB_ADDR_W+1)'(take_eff) - (ROB_ADDR_W+1)'(commit_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    alloc_avail = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      alloc_avail[i] = free_slots > (ROB_ADDR_W+1)'(i);
    end
  end

  always_comb begin
    occ = OCC_PARTIAL;
    if (count_q == '0)
      occ = OCC_EMPTY;
    else if (count_q == (ROB_ADDR_W+1)'(ROB_DEPTH))
      occ = OCC_FULL;
  end

  assign rob_head  = head_q;
  assign rob_count = count_q;
  assign rob_full  = (occ == OCC_FULL);
  assign rob_empty = (occ == OCC_EMPTY);
  assign proto_err = err_q;

endmodule

// File: tb/tb_rob_alloc.sv
// Self-checking bench for rob_alloc: arithmetic reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_rob_alloc;

  localparam int W  = 4;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] alloc_take;
  logic [CW-1:0] commit_count;
  logic          flush;
  logic [AW*W-1:0] rob_entries;
  logic [W-1:0]  alloc_avail;
  logic [AW-1:0] rob_head;
  logic [AW:0]   rob_count;
  logic          rob_full, rob_empty, proto_err;

  int n_cmp  = 0;
  int n_fail = 0;

  rob_alloc #(.WIDTH(W), .ROB_DEPTH(D), .ROB_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .alloc_take(alloc_take), .commit_count(commit_count),
    .flush(flush), .rob_entries(rob_entries), .alloc_avail(alloc_avail),
    .rob_head(rob_head), .rob_count(rob_count), .rob_full(rob_full),
    .rob_empty(rob_empty), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers for head, tail, occupancy and error.
  int m_head, m_tail, m_count;
  bit m_err;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_head = 0; m_tail = 0; m_count = 0; m_err = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      int t, c;
      t = int'(alloc_take);
      c = int'(commit_count);
      if (t > W || t > D - m_count) begin m_err = 1'b1; t = 0; end
      if (c > W || c > m_count)     begin m_err = 1'b1; c = 0; end
      m_head = (m_head + c) % D;
      if (flush) begin
        m_tail  = m_head;
        m_count = 0;
      end else begin
        m_tail  = (m_tail + t) % D;
        m_count = m_count + t - c;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      logic [AW*W-1:0] e_entries;
      logic [W-1:0]    e_avail;
      for (int i = 0; i < W; i++) begin
        e_entries[i*AW +: AW] = AW'((m_tail + i) % D);
        e_avail[i]            = (D - m_count) > i;
      end
      chk("model_entries", 32'(rob_entries), 32'(e_entries));
      chk("model_avail",   32'(alloc_avail), 32'(e_avail));
      chk("model_head",    32'(rob_head),    32'(m_head));
      chk("model_count",   32'(rob_count),   32'(m_count));
      chk("model_full",    32'(rob_full),    32'(m_count == D));
      chk("model_empty",   32'(rob_empty),   32'(m_count == 0));
      chk("model_err",     32'(proto_err),   32'(m_err));
    end
  end

  task automatic step(input int t, input int c, input bit f, input bit r);
    alloc_take   = CW'(t);
    commit_count = CW'(c);
    flush        = f;
    rst          = r;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; alloc_take = '0; commit_count = '0; flush = 1'b0;
    do_reset();

    // Reset state
    chk("rst_entries", 32'(rob_entries), 32'({5'd3, 5'd2, 5'd1, 5'd0}));
    chk("rst_avail",   32'(alloc_avail), 32'(4'b1111));
    chk("rst_empty",   32'(rob_empty),   32'd1);
    chk("rst_err",     32'(proto_err),   32'd0);

    // Fill completely, then overflow by one
    for (int i = 0; i < 8; i++) step(4, 0, 0, 0);
    chk("fill_count", 32'(rob_count),   32'd32);
    chk("fill_full",  32'(rob_full),    32'd1);
    chk("fill_avail", 32'(alloc_avail), 32'd0);
    step(1, 0, 0, 0);
    chk("ovf_err",   32'(proto_err), 32'd1);
    chk("ovf_count", 32'(rob_count), 32'd32);

    // Fill to 30: partial availability, tail wrap in lanes, over-take rejected
    do_reset();
    for (int i = 0; i < 7; i++) step(4, 0, 0, 0);
    step(2, 0, 0, 0);
    chk("f30_avail",   32'(alloc_avail), 32'(4'b0011));
    chk("f30_entries", 32'(rob_entries), 32'({5'd1, 5'd0, 5'd31, 5'd30}));
    chk("f30_err0",    32'(proto_err),   32'd0);
    step(3, 0, 0, 0);
    chk("f30_err1",    32'(proto_err),   32'd1);
    chk("f30_count",   32'(rob_count),   32'd30);
    step(2, 0, 0, 0);
    chk("f32_count",   32'(rob_count),   32'd32);
    chk("f32_tail",    32'(rob_entries[AW-1:0]), 32'd0);

    // Simultaneous take and commit
    do_reset();
    step(4, 0, 0, 0); step(4, 0, 0, 0); step(2, 0, 0, 0);
    step(4, 3, 0, 0);
    chk("sim_count", 32'(rob_count), 32'd11);
    chk("sim_head",  32'(rob_head),  32'd3);
    chk("sim_tail",  32'(rob_entries[AW-1:0]), 32'd14);

    // head 30, tail 2, count 4; commit wraps head
    do_reset();
    for (int i = 0; i < 7; i++) step(4, 0, 0, 0);
    step(2, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 4, 0, 0);
    step(0, 2, 0, 0);
    step(4, 0, 0, 0);
    chk("wrap_entries", 32'(rob_entries), 32'({5'd5, 5'd4, 5'd3, 5'd2}));
    chk("wrap_head",    32'(rob_head),    32'd30);
    step(0, 4, 0, 0);
    chk("wrap_head2",   32'(rob_head),    32'd2);
    chk("wrap_empty",   32'(rob_empty),   32'd1);

    // Flush with same-cycle commit, then an over-commit
    do_reset();
    step(4, 0, 0, 0); step(4, 0, 0, 0); step(4, 0, 0, 0);
    step(0, 2, 1, 0);
    chk("fl_head",  32'(rob_head),  32'd2);
    chk("fl_tail",  32'(rob_entries[AW-1:0]), 32'd2);
    chk("fl_count", 32'(rob_count), 32'd0);
    chk("fl_err",   32'(proto_err), 32'd0);
    step(3, 0, 0, 0);
    step(0, 5, 0, 0);
    chk("oc_err",  32'(proto_err), 32'd1);
    chk("oc_head", 32'(rob_head),  32'd2);

    // Randomized traffic, mostly legal, with occasional flush and reset
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      int t, c, free;
      bit f, r;
      free = D - m_count;
      if ($urandom_range(0, 99) < 8) t = int'($urandom_range(0, 7));
      else t = int'($urandom_range(0, (free < W) ? free : W));
      if ($urandom_range(0, 99) < 8) c = int'($urandom_range(0, 7));
      else c = int'($urandom_range(0, (m_count < W) ? m_count : W));
      f = ($urandom_range(0, 99) < 3);
      r = ($urandom_range(0, 199) < 1);
      step(t, c, f, r);
    end

    step(0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_alloc.md
# rob_alloc

Allocates reorder-buffer slots to the rename/decode lanes and reclaims them at commit. Manages the ROB as a circular buffer with head, tail and occupancy registers. Each cycle it presents up to WIDTH consecutive free ROB indices to the decoder, which consumes a prefix of them. The commit stage retires a prefix of entries from the head. Supports full flush on misprediction/exception and detects protocol violations.

## Interface
- WIDTH, 4, decode/commit lanes per cycle (1..8)
- ROB_DEPTH, 32, ROB entries; power of two, greater than or equal to 2*WIDTH
- ROB_ADDR_W, 5, log2(ROB_DEPTH)
- CNT_W, 3, ceil(log2(WIDTH+1)); width of per-cycle count ports

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- alloc_take  in  CNT_W  number of offered entries the decoder consumes this cycle (lanes 0..take-1)
- commit_count  in  CNT_W  entries retired from head this cycle
- flush  in  1  discard all allocated entries
- rob_entries  out  ROB_ADDR_W*WIDTH  lane i = (tail+i) mod ROB_DEPTH
- alloc_avail  out  WIDTH  thermometer; bit i set iff free_slots > i
- rob_head  out  ROB_ADDR_W  oldest allocated entry
- rob_count  out  ROB_ADDR_W+1  occupied entries, 0..ROB_DEPTH
- rob_full  out  1  rob_count == ROB_DEPTH
- rob_empty  out  1  rob_count == 0
- proto_err  out  1  sticky violation flag; cleared only by rst

## Operation
- State registers: head and tail (ROB_ADDR_W bits each), count (ROB_ADDR_W+1 bits), err.
- free_slots = ROB_DEPTH - count.
- Allocation:
  - take is legal iff take <= WIDTH and take <= free_slots.
  - A legal take advances tail by take, modulo ROB_DEPTH with natural wrap.
  - An illegal take sets err and is treated as 0.
- Commit:
  - commit is legal iff commit_count <= WIDTH and commit_count <= count (count as registered this cycle, before this cycle's allocation).
  - A legal commit advances head by commit_count.
  - An illegal commit sets err and is treated as 0.
- Simultaneous alloc and commit: count_next = count + take_eff - commit_eff. Same-cycle commit does not free slots for same-cycle allocation; alloc_avail reflects registered count only.
- Flush has priority over alloc and commit in the same cycle:
  - tail_next = head_next, where head_next includes a legal same-cycle commit.
  - count_next = 0.
  - Legality checks still run and can set err.
- The state machine is implicit in count: EMPTY (count 0), PARTIAL, FULL (count ROB_DEPTH). Wrap-around is not tracked separately; count disambiguates head == tail.
- rob_entries is driven for all lanes regardless of availability. Consumers gate lanes with alloc_avail.

## Timing
- All outputs are combinational functions of registered state only. There are no paths from inputs to outputs.
- Latency: alloc/commit/flush become visible in rob_entries, alloc_avail and rob_count on the next cycle.
- Reset values: head 0, tail 0, count 0, err 0. Hence rob_entries lane i = i, alloc_avail all ones, rob_head 0, rob_count 0, rob_empty 1, rob_full 0, proto_err 0.
- rst has priority over every other input. Asserting rst mid-operation discards all state in one cycle.
- Boundary behaviour:
  - count = ROB_DEPTH: alloc_avail = 0. Any take > 0 is an error.
  - count = ROB_DEPTH-k with k < WIDTH: alloc_avail = lowest k bits set.
  - Tail wrap: with tail = ROB_DEPTH-2 and WIDTH 4, the lanes read ROB_DEPTH-2, ROB_DEPTH-1, 0, 1.

## Structure
- Add ROB_DEPTH and ROB_ADDR_W to constants.vh, next to PHYS_REGS and PR_ADDR_W. The decoder's ROB_entries width derives from them.
- A single module, plus one sub-module rob_ptr_adv that performs modulo pointer add (ptr + n). It is instantiated twice, for head and tail, and reused by the lane-index generator.
- No memories. The payload ROB storage lives elsewhere and is indexed by these pointers.

## Test plan
- Reset, then idle → rob_entries = {3,2,1,0} (lane 3 to lane 0), alloc_avail = 4'b1111, rob_empty = 1, proto_err = 0.
- Take 4 every cycle for 8 cycles, no commit → rob_count 32, rob_full = 1, alloc_avail = 0. A ninth take of 1 → proto_err = 1 and count stays 32.
- Fill to 30, then take 3 → error, state unchanged. Take 2 → count 32, tail wraps to 0.
- count 10 with simultaneous take 4 and commit 3 → next count 11, head +3, tail +4.
- head = 30, tail = 2, count 4 → rob_entries = {5,4,3,2}. Commit 4 → head wraps to 2, rob_empty = 1.
- count 12 with flush plus commit 2 in the same cycle → head +2, tail = head, count 0, no error. Separately, commit 5 with count 3 → proto_err = 1, head unchanged.
